// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder: FSM encoding, bus widths
// and the word-index slice position within a byte address.
package mem_if_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

  // Word index occupies addr[WIDX_MSB:WIDX_LSB]; the low bits select a byte.
  localparam int WIDX_LSB = 2;
  localparam int WIDX_MSB = ADDR_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between a requester (master) and the
// memory responder (slave).
interface mem_responder_if;
  import mem_if_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [WORD_BYTES-1:0] req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_array.sv
// Synchronous word RAM with per-byte write enables and a registered read
// port. The read register only updates on an enabled read, so its value
// stays put while a response is being held.
module mem_array
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Byte-masked write or registered full-word read, one per enabled edge.
  // NOTE: the storage array has no reset; clearing it would need a loop over
  // every word and the contents are meant to survive a reset anyway.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder: accepts one transaction at a time, waits
// LATENCY cycles, performs the checked array access, then holds the
// response until the requester consumes it.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic          clk,
  input  logic          rst,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // Request holding registers, loaded once at acceptance.
  logic                  we_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [WORD_BYTES-1:0] be_q;

  // Response qualifiers captured at the access edge.
  logic                  err_q;
  logic                  rd_ok_q;

  logic                  accept;
  logic                  access;
  logic                  acc_err;
  logic                  ram_en;
  logic [DATA_W-1:0]     ram_rdata;

  // Misaligned or beyond the array: reject instead of aliasing.
  assign acc_err = (addr_q[WIDX_LSB-1:0] != '0) ||
                   (addr_q[WIDX_MSB:WIDX_LSB] >= (WIDX_MSB-WIDX_LSB+1)'(DEPTH_WORDS));

  // A reset coinciding with the access edge aborts the transaction.
  assign ram_en = access && !acc_err && !rst;

  // Next-state, handshake outputs and counter update.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    accept        = 1'b0;
    access        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Counter reaching zero marks the access edge; LATENCY wait cycles
        // precede it, so the response appears LATENCY+1 edges after accept.
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, holding and response-flag registers.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
      if (access) begin
        err_q   <= acc_err;
        rd_ok_q <= !we_q && !acc_err;
      end
    end
  end

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_q),
    .be    (be_q),
    .addr  (addr_q[WIDX_LSB +: IDX_W]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Read data only for successful reads; zero for writes, errors and idle.
  assign bus.rsp_rdata = (state_q == RESP && rd_ok_q) ? ram_rdata : '0;
  assign bus.rsp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder with a word-array reference model.
module tb_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LAT     = 2;
  localparam int INIT_WD = 64;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [31:0] ref_mem [DEPTH];

  mem_responder_if bus ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  // Expected response for a transaction, and the model update it implies.
  task automatic model_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rd, output logic er);
    rd = 32'h0;
    er = addr_bad(a);
    if (!er) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[a / 4][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rd = ref_mem[a / 4];
      end
    end
  endtask

  task automatic drive_req(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
  endtask

  // After acceptance the request inputs are scrambled to prove they are held.
  task automatic scramble_req();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_be    = 4'($urandom);
  endtask

  task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold);
    int          cyc;
    logic [31:0] exp_rd;
    logic        exp_er;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive_req(we, a, wd, be);
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    scramble_req();
    cyc = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, LAT + 1);
    model_txn(we, a, wd, be, exp_rd, exp_er);
    check("rsp_err", 32'(bus.rsp_err), 32'(exp_er));
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rdata", bus.rsp_rdata, exp_rd);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    check("req_ready_back", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'($urandom_range(0, INIT_WD - 1) * 4 + $urandom_range(1, 3));
    if (sel == 1) begin
      case ($urandom_range(0, 2))
        0: return 32'(DEPTH * 4);
        1: return 32'(DEPTH * 4) + 32'($urandom_range(0, 255) * 4);
        default: return $urandom | 32'h8000_0000;
      endcase
    end
    return 32'($urandom_range(0, INIT_WD - 1) * 4);
  endfunction

  initial begin
    int          bad;
    int          cyc;
    logic [31:0] exp_rd;
    logic        exp_er;

    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.rsp_ready = 1'b0;
    drive_req(1'b1, 32'h14, 32'h1234_5678, 4'hF);

    // Request presented only while reset is held must not be taken.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) bad++;
    end
    check("reset_req_ignored", bad, 0);

    for (int w = 0; w < INIT_WD; w++) txn(1'b1, 32'(w * 4), $urandom, 4'hF, 0);

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h10, 32'h0000_0055, 4'b0001, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    check("byte_merge", ref_mem[4], 32'hDEAD_BE55);
    txn(1'b0, 32'h12, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h1000, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 0);
    txn(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1'b0, 32'hFFC, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h18, 32'hAAAA_AAAA, 4'b0000, 0);
    txn(1'b0, 32'h18, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5);

    // Reset during WAIT: write is abandoned and no response appears.
    @(negedge clk);
    drive_req(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
    @(posedge clk); #1;
    scramble_req();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) bad++;
    end
    check("abort_no_rsp", bad, 0);
    check("abort_idle", 32'(bus.req_ready), 32'd1);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 0);

    // Reset during RESP: response dropped, write already applied.
    @(negedge clk);
    drive_req(1'b1, 32'h24, 32'h0BAD_F00D, 4'hF);
    @(posedge clk); #1;
    scramble_req();
    cyc = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("resp_rst_latency", cyc, LAT + 1);
    model_txn(1'b1, 32'h24, 32'h0BAD_F00D, 4'hF, exp_rd, exp_er);
    rst = 1'b1;
    @(posedge clk); #1;
    check("resp_rst_drop", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    txn(1'b0, 32'h24, 32'h0, 4'h0, 0);

    for (int n = 0; n < 300; n++) begin
      txn(1'($urandom), rand_addr(), $urandom, 4'($urandom),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
